// File: rtl/demux_deserializer_if.sv
// demux_deserializer_if: channel input and round-robin output port bundle for the deserializer
interface demux_deserializer_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic [3:0] ch_in;
  logic [1:0] ch_sel;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0] out_ch;
  logic [3:0] ovf;
  modport master (
    output in_valid, ch_in, ch_sel, out_ready,
    input out_valid, out_data, out_ch, ovf
  );
  modport slave (
    input in_valid, ch_in, ch_sel, out_ready,
    output out_valid, out_data, out_ch, ovf
  );
endinterface

// File: rtl/demux_deserializer.sv
// demux_deserializer: per-channel MSB-first deserializers with held words drained round-robin
module demux_deserializer #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  demux_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr [4];
  logic [WIDTH-1:0] hold [4];
  logic [CW-1:0] cnt [4];
  logic [3:0] full;
  logic [3:0] ovf;
  logic [1:0] rr;
  logic [1:0] sel;
  logic [1:0] c;
  logic b;
  logic any;
  logic drain;
  logic last;
  logic room;
  logic [WIDTH-1:0] word;
  // round-robin pick: scan from rr+3 down to rr so the nearest full channel wins
  always_comb begin
    sel = rr;
    for (int k = 3; k >= 0; k--) sel = full[rr + 2'(k)] ? rr + 2'(k) : sel;
  end
  assign any = |full;
  assign bus.out_valid = any;
  assign bus.out_ch = any ? sel : 2'd0;
  assign bus.out_data = any ? hold[sel] : '0;
  assign bus.ovf = ovf;
  assign c = bus.ch_sel;
  assign b = bus.ch_in[c];
  assign drain = any & bus.out_ready;
  assign last = cnt[c] == CW'(WIDTH - 1);
  assign room = !full[c] | (drain & (sel == c));
  assign word = {sr[c][WIDTH-2:0], b};
  // drain first so a same-edge refill of the drained channel keeps full set
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sr[i] <= '0;
        hold[i] <= '0;
        cnt[i] <= '0;
      end
      full <= '0;
      ovf <= '0;
      rr <= '0;
    end else begin
      if (drain) begin
        full[sel] <= 1'b0;
        rr <= sel + 2'd1;
      end
      if (bus.in_valid) begin
        sr[c] <= word;
        cnt[c] <= last ? '0 : cnt[c] + 1'b1;
        if (last && room) begin
          hold[c] <= word;
          full[c] <= 1'b1;
        end
        if (last && !room) ovf[c] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_demux_deserializer.sv
// tb_demux_deserializer: table vectors, directed corner sequences and random traffic vs a queue-level model
module tb_demux_deserializer;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  demux_deserializer_if #(.WIDTH(W)) bus ();
  demux_deserializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int m_cnt [4];
  int m_acc [4];
  int m_hold [4];
  bit m_full [4];
  int m_ovf;
  int m_rr;
  typedef struct {
    bit iv;
    logic [3:0] chin;
    logic [1:0] sel;
    bit rdy;
    bit ev;
    int ed;
    int ec;
    int eo;
  } vec_t;
  vec_t tbl [9];
  function automatic int m_pick();
    for (int k = 0; k < 4; k++) if (m_full[(m_rr + k) % 4]) return (m_rr + k) % 4;
    return -1;
  endfunction
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_outs();
    int s;
    s = m_pick();
    check("out_valid", int'(bus.out_valid), s >= 0 ? 1 : 0);
    check("out_data", int'(bus.out_data), s >= 0 ? m_hold[s] : 0);
    check("out_ch", int'(bus.out_ch), s >= 0 ? s : 0);
    check("ovf", int'(bus.ovf), m_ovf);
  endtask
  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m_acc[i] = 0;
      m_hold[i] = 0;
      m_full[i] = 0;
    end
    m_ovf = 0;
    m_rr = 0;
  endtask
  task automatic m_step(input bit iv, input logic [3:0] chin, input int sel, input bit rdy);
    int s;
    s = m_pick();
    if (s >= 0 && rdy) begin
      m_full[s] = 0;
      m_rr = (s + 1) % 4;
    end
    if (iv) begin
      m_acc[sel] = (m_acc[sel] * 2 + int'(chin[sel])) % (1 << W);
      m_cnt[sel]++;
      if (m_cnt[sel] == W) begin
        m_cnt[sel] = 0;
        if (!m_full[sel]) begin
          m_hold[sel] = m_acc[sel];
          m_full[sel] = 1;
        end else m_ovf = m_ovf | (1 << sel);
      end
    end
  endtask
  task automatic cyc(input bit iv, input logic [3:0] chin, input int sel, input bit rdy);
    bus.in_valid = iv;
    bus.ch_in = chin;
    bus.ch_sel = 2'(sel);
    bus.out_ready = rdy;
    @(posedge clk);
    m_step(iv, chin, sel, rdy);
    #1;
    check_outs();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.ch_in = 4'hF;
    bus.ch_sel = 2'd0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    m_reset();
    #1;
    rst = 1'b0;
    check_outs();
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
  endtask
  task automatic send_bit(input int c, input bit b, input bit rdy);
    logic [3:0] chin;
    chin = 4'($urandom);
    chin[c] = b;
    cyc(1'b1, chin, c, rdy);
  endtask
  task automatic send_byte(input int c, input logic [7:0] v, input bit rdy);
    for (int i = W - 1; i >= 0; i--) send_bit(c, v[i], rdy);
  endtask
  initial begin
    logic [7:0] pat;
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      tbl[i].iv = 1'b1;
      tbl[i].chin = pat[7-i] ? 4'b0100 : 4'b1011;
      tbl[i].sel = 2'd2;
      tbl[i].rdy = 1'b1;
      tbl[i].ev = (i == 7);
      tbl[i].ed = (i == 7) ? 'hB2 : 0;
      tbl[i].ec = (i == 7) ? 2 : 0;
      tbl[i].eo = 0;
    end
    tbl[8] = '{iv: 1'b0, chin: 4'hF, sel: 2'd1, rdy: 1'b1, ev: 1'b0, ed: 0, ec: 0, eo: 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].iv, tbl[i].chin, int'(tbl[i].sel), tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), int'(bus.out_valid), int'(tbl[i].ev));
      check($sformatf("tbl%0d_data", i), int'(bus.out_data), tbl[i].ed);
      check($sformatf("tbl%0d_ch", i), int'(bus.out_ch), tbl[i].ec);
      check($sformatf("tbl%0d_ovf", i), int'(bus.ovf), tbl[i].eo);
    end
    do_reset();
    begin
      logic [7:0] a;
      logic [7:0] z;
      a = 8'hA5;
      z = 8'h3C;
      for (int i = 7; i >= 0; i--) begin
        send_bit(0, a[i], 1'b0);
        send_bit(3, z[i], 1'b0);
      end
    end
    check("il_first_ch", int'(bus.out_ch), 0);
    check("il_first_data", int'(bus.out_data), 'hA5);
    cyc(1'b0, 4'h0, 0, 1'b1);
    check("il_second_ch", int'(bus.out_ch), 3);
    check("il_second_data", int'(bus.out_data), 'h3C);
    cyc(1'b0, 4'h0, 0, 1'b1);
    check("il_empty", int'(bus.out_valid), 0);
    send_byte(2, 8'h5E, 1'b0);
    check("il_rr_back_to_0", int'(bus.out_ch), 2);
    do_reset();
    send_byte(1, 8'h5A, 1'b0);
    send_byte(1, 8'hFF, 1'b0);
    check("ovf_flag", int'(bus.ovf), 'b0010);
    check("ovf_hold_kept", int'(bus.out_data), 'h5A);
    cyc(1'b0, 4'h0, 0, 1'b1);
    send_byte(1, 8'h33, 1'b0);
    check("ovf_third_byte", int'(bus.out_data), 'h33);
    check("ovf_sticky", int'(bus.ovf), 'b0010);
    do_reset();
    send_byte(1, 8'h22, 1'b0);
    begin
      logic [7:0] v;
      v = 8'h11;
      for (int i = 7; i >= 1; i--) send_bit(1, v[i], 1'b0);
      check("same_before", int'(bus.out_data), 'h22);
      send_bit(1, v[0], 1'b1);
    end
    check("same_valid", int'(bus.out_valid), 1);
    check("same_data", int'(bus.out_data), 'h11);
    check("same_ovf", int'(bus.ovf), 0);
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) send_byte(c, 8'(8'h10 + 8'(c) + 8'(r * 16)), 1'b0);
      for (int c = 0; c < 4; c++) begin
        check($sformatf("rr_ch_r%0d_%0d", r, c), int'(bus.out_ch), c);
        check($sformatf("rr_data_r%0d_%0d", r, c), int'(bus.out_data), 'h10 + c + r * 16);
        cyc(1'b0, 4'h0, 0, 1'b1);
      end
      check($sformatf("rr_empty_r%0d", r), int'(bus.out_valid), 0);
    end
    do_reset();
    send_byte(0, 8'h77, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(2, 1'b1, 1'b0);
    do_reset();
    check("rst_mid_ch", int'(bus.out_ch), 0);
    check("rst_mid_ovf", int'(bus.ovf), 0);
    send_byte(2, 8'hC3, 1'b0);
    check("rst_fresh_data", int'(bus.out_data), 'hC3);
    check("rst_fresh_ch", int'(bus.out_ch), 2);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit iv;
      bit rdy;
      iv = $urandom_range(0, 9) < 8;
      rdy = $urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 8);
      cyc(iv, 4'($urandom), int'($urandom_range(0, 3)), rdy);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
